// File: rtl/fir_pkg.sv
// Shared FIR constants and the round/scale/saturate helper used by output and gain stages.
package fir_pkg;

  localparam int FIR_WIDTH     = 8;
  localparam int FIR_ACC_WIDTH = 2*FIR_WIDTH + 2;
  localparam int SR_W          = 32;

  typedef struct packed {
    logic signed [SR_W-1:0] value;
    logic                   sat;
  } sat_round_t;

  // Round half up, arithmetic shift right, clamp to a signed out_w-bit range.
  function automatic sat_round_t sat_round(input logic signed [SR_W-1:0] value,
                                           input int shift, input int out_w);
    sat_round_t             res;
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    r = value;
    if (shift > 0) r = r + (32'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    res.value = r;
    res.sat   = 1'b0;
    if (r > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (r < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_decim_out_sync_fifo.sv
// Small synchronous FIFO with natural-wrap pointers and an explicit occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_en;
  logic             rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;
  assign rd_en = pop && !empty;
  // A write into a full buffer is legal only when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: decimate, round/scale/saturate, then buffer for a valid/ready sink.
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int IN_WIDTH   = FIR_ACC_WIDTH,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 2,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        sat_flag,
  output logic [7:0]                  drop_cnt
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [PW-1:0]        phase;
  logic                 keep;
  sat_round_t           scaled;
  logic                 s1_valid;
  logic [OUT_WIDTH-1:0] s1_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count_unused;
  logic [OUT_WIDTH-1:0] fifo_dout;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign keep   = in_valid && (phase == '0);
  assign scaled = sat_round(SR_W'(in_data), SHIFT, OUT_WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= (phase == PW'(DECIM-1)) ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      sat_flag <= 1'b0;
    end else begin
      s1_valid <= keep;
      if (keep) begin
        s1_data  <= scaled.value[OUT_WIDTH-1:0];
        sat_flag <= sat_flag | scaled.sat;
      end
    end
  end

  // The filter free-runs, so a full buffer loses the sample and only counts it.
  assign pop  = out_ready && !fifo_empty;
  assign push = s1_valid && (!fifo_full || pop);
  assign drop = s1_valid && !push;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (s1_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout;

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: queue-based reference model checked every cycle plus directed literals.
module tb_fir_decim_out;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_reset, a_in_valid, a_out_valid, a_out_ready, a_sat_flag;
  logic signed [17:0] a_in_data;
  logic signed [7:0]  a_out_data;
  logic [7:0]         a_drop_cnt;
  logic              b_reset, b_in_valid, b_out_valid, b_out_ready, b_sat_flag;
  logic signed [17:0] b_in_data;
  logic signed [7:0]  b_out_data;
  logic [7:0]         b_drop_cnt;

  fir_decim_out #(.IN_WIDTH(18), .OUT_WIDTH(8), .SHIFT(2), .DECIM(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .sat_flag(a_sat_flag), .drop_cnt(a_drop_cnt));

  fir_decim_out #(.IN_WIDTH(18), .OUT_WIDTH(8), .SHIFT(0), .DECIM(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .sat_flag(b_sat_flag), .drop_cnt(b_drop_cnt));

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int m_phase [2];
  bit m_pv    [2];
  int m_pd    [2];
  int mq      [2][$];
  bit m_sat   [2];
  int m_drop  [2];
  bit m_live = 1'b0;
  int logq    [2][$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Floor division of (x + half) by 2^sh, then clamp to signed 8 bits.
  function automatic int ref_scale(input int x, input int sh, output bit clamp);
    int d, v, q;
    d = 1 << sh;
    v = x + ((sh > 0) ? d / 2 : 0);
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    clamp = 1'b0;
    if (q > 127) begin q = 127; clamp = 1'b1; end
    if (q < -128) begin q = -128; clamp = 1'b1; end
    return q;
  endfunction

  task automatic model_step(input int k, input bit rst, input bit iv, input int id,
                            input bit rdy, input int sh, input int dc);
    bit c;
    if (rst) begin
      m_phase[k] = 0; m_pv[k] = 1'b0; m_pd[k] = 0;
      mq[k].delete(); m_sat[k] = 1'b0; m_drop[k] = 0;
    end else begin
      if (mq[k].size() > 0 && rdy) void'(mq[k].pop_front());
      if (m_pv[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(m_pd[k]);
        else if (m_drop[k] < 255) m_drop[k]++;
      end
      m_pv[k] = 1'b0;
      if (iv && m_phase[k] == 0) begin
        m_pd[k] = ref_scale(id, sh, c);
        m_pv[k] = 1'b1;
        if (c) m_sat[k] = 1'b1;
      end
      if (iv) m_phase[k] = (m_phase[k] + 1) % dc;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, a_reset, a_in_valid, int'(a_in_data), a_out_ready, 2, 2);
    model_step(1, b_reset, b_in_valid, int'(b_in_data), b_out_ready, 0, 1);
    m_live = 1'b1;
  end

  task automatic compare(input int k, input bit ov, input int od, input bit sf, input int dcnt);
    chk($sformatf("out_valid[%0d]", k), int'(ov), (mq[k].size() > 0) ? 1 : 0);
    chk($sformatf("out_data[%0d]", k), od, (mq[k].size() > 0) ? mq[k][0] : 0);
    chk($sformatf("sat_flag[%0d]", k), int'(sf), int'(m_sat[k]));
    chk($sformatf("drop_cnt[%0d]", k), dcnt, m_drop[k]);
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      compare(0, a_out_valid, int'(a_out_data), a_sat_flag, int'(a_drop_cnt));
      compare(1, b_out_valid, int'(b_out_data), b_sat_flag, int'(b_drop_cnt));
      if (!a_reset && a_out_valid && a_out_ready) logq[0].push_back(int'(a_out_data));
      if (!b_reset && b_out_valid && b_out_ready) logq[1].push_back(int'(b_out_data));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit v, input int d);
    a_in_valid = v;
    a_in_data  = 18'(d);
    step();
  endtask

  task automatic chk_log(input string name, input int k, input int idx, input int exp);
    chk(name, (logq[k].size() > idx) ? logq[k][idx] : -999, exp);
  endtask

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    step(); step();
    chk("reset_out_valid", int'(a_out_valid), 0);
    chk("reset_out_data", int'(a_out_data), 0);
    chk("reset_drop_cnt", int'(a_drop_cnt), 0);
    a_reset = 1'b0; b_reset = 1'b0;

    // Decimation, rounding and latency
    a_in_valid = 1'b1; a_in_data = 18'(10);
    step();
    chk("t1_lat_edge1", int'(a_out_valid), 0);
    a_in_data = 18'(99);
    step();
    chk("t1_lat_edge2", int'(a_out_valid), 1);
    chk("t1_first", int'(a_out_data), 3);
    drive_a(1'b1, -3);
    drive_a(1'b1, 99);
    a_in_valid = 1'b0;
    repeat (3) step();
    chk("t1_count", logq[0].size(), 2);
    chk_log("t1_out0", 0, 0, 3);
    chk_log("t1_out1", 0, 1, -1);

    // Saturation and sticky flag
    a_reset = 1'b1; step(); a_reset = 1'b0;
    logq[0].delete();
    chk("t2_sat_clear", int'(a_sat_flag), 0);
    drive_a(1'b1, 1000); drive_a(1'b1, 0);
    drive_a(1'b1, -1000); drive_a(1'b1, 0);
    drive_a(1'b1, 4); drive_a(1'b1, 0);
    a_in_valid = 1'b0;
    repeat (3) step();
    chk_log("t2_pos_sat", 0, 0, 127);
    chk_log("t2_neg_sat", 0, 1, -128);
    chk_log("t2_small", 0, 2, 1);
    chk("t2_sat_sticky", int'(a_sat_flag), 1);

    // Back-pressure fills the buffer and counts losses
    logq[0].delete();
    a_out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive_a(1'b1, 4*i);
      drive_a(1'b1, 0);
    end
    a_in_valid = 1'b0;
    repeat (3) step();
    chk("t3_drop_cnt", int'(a_drop_cnt), 2);
    chk("t3_head", int'(a_out_data), 1);
    chk("t3_nothing_popped", logq[0].size(), 0);

    // Full buffer: pop and push in the same cycle
    drive_a(1'b1, 28);
    a_in_data = 18'(0);
    a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    chk("t4_drop_same", int'(a_drop_cnt), 2);
    chk("t4_head", int'(a_out_data), 2);
    repeat (6) step();
    chk("t4_total", logq[0].size(), 5);
    chk_log("t4_out0", 0, 0, 1);
    chk_log("t4_out1", 0, 1, 2);
    chk_log("t4_out2", 0, 2, 3);
    chk_log("t4_out3", 0, 3, 4);
    chk_log("t4_out4", 0, 4, 7);

    // Reset mid-stream
    logq[0].delete();
    a_out_ready = 1'b0;
    drive_a(1'b1, 1000); drive_a(1'b1, 0);
    drive_a(1'b1, 8);    drive_a(1'b1, 0);
    drive_a(1'b1, 12);   drive_a(1'b1, 0);
    drive_a(1'b1, 20);
    chk("t5_pre_sat", int'(a_sat_flag), 1);
    chk("t5_pre_drop", int'(a_drop_cnt), 2);
    a_in_valid = 1'b0; a_reset = 1'b1;
    step();
    chk("t5_out_valid", int'(a_out_valid), 0);
    chk("t5_drop", int'(a_drop_cnt), 0);
    chk("t5_sat", int'(a_sat_flag), 0);
    a_reset = 1'b0; a_out_ready = 1'b1;
    drive_a(1'b1, 16); drive_a(1'b1, 40);
    a_in_valid = 1'b0;
    repeat (3) step();
    chk("t5_count", logq[0].size(), 1);
    chk_log("t5_first_kept", 0, 0, 4);

    // Pass-through instance: no decimation, no scaling
    b_in_valid = 1'b1;
    b_in_data = 18'(127);  step();
    b_in_data = 18'(128);  step();
    b_in_data = 18'(-129); step();
    b_in_valid = 1'b0;
    repeat (4) step();
    chk("t6_count", logq[1].size(), 3);
    chk_log("t6_out0", 1, 0, 127);
    chk_log("t6_out1", 1, 1, 127);
    chk_log("t6_out2", 1, 2, -128);
    chk("t6_sat", int'(b_sat_flag), 1);
    chk("t6_drop", int'(b_drop_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
